// File: rtl/gates_sweep_ctrl_if.sv
// Gate-bank bus: the sweep controller (master) drives {sel, in1, in0} into one gate-bank
// instance (slave) and reads back its seven outputs {dmux2, dmux1, mux, xor, or, and, not}.
interface gates_sweep_ctrl_if;
    logic       in0;
    logic       in1;
    logic       sel;
    logic [6:0] gate_out;

    modport master (
        output in0,
        output in1,
        output sel,
        input  gate_out
    );

    modport slave (
        input  in0,
        input  in1,
        input  sel,
        output gate_out
    );
endinterface

// File: rtl/gates_sweep_ctrl.sv
// Self-test sequencer: sweeps all eight {sel, in1, in0} vectors through a gate bank and checks
// the outputs against golden logic. Define GATES_SWEEP_LOG_EN to add the o_result_log capture.
module gates_sweep_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    gates_sweep_ctrl_if.master io_bank,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic [6:0]         o_fail_mask,
    output logic [2:0]         o_first_fail_vec,
    output logic               o_first_fail_valid
`ifdef GATES_SWEEP_LOG_EN
    ,
    output logic [55:0]        o_result_log
`endif
);

    localparam logic [3:0] SettleW = 4'(SETTLE);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_vec, w_vec_nxt;
    logic [3:0] r_wcnt, w_wcnt_nxt;
    logic [2:0] r_drive, w_drive_nxt;
    logic [6:0] r_fail_mask, w_fail_mask_nxt;
    logic [2:0] r_ffv, w_ffv_nxt;
    logic       r_ffvalid, w_ffvalid_nxt;
    logic       r_pass, w_pass_nxt;
    logic [6:0] w_golden;
    logic [6:0] w_diff;
`ifdef GATES_SWEEP_LOG_EN
    logic [55:0] r_log, w_log_nxt;
`endif

    // r_vec only changes in RUN, where it always equals the driven vector.
    always_comb begin
        w_golden = {r_vec[0] & r_vec[2],
                    r_vec[0] & ~r_vec[2],
                    r_vec[2] ? r_vec[1] : r_vec[0],
                    r_vec[0] ^ r_vec[1],
                    r_vec[0] | r_vec[1],
                    r_vec[0] & r_vec[1],
                    ~r_vec[0]};
        w_diff   = w_golden ^ io_bank.gate_out;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_vec_nxt       = r_vec;
        w_wcnt_nxt      = r_wcnt;
        w_fail_mask_nxt = r_fail_mask;
        w_ffv_nxt       = r_ffv;
        w_ffvalid_nxt   = r_ffvalid;
        w_pass_nxt      = r_pass;
`ifdef GATES_SWEEP_LOG_EN
        w_log_nxt       = r_log;
`endif
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt     = StRun;
                    w_vec_nxt       = 3'd0;
                    w_wcnt_nxt      = 4'd0;
                    w_fail_mask_nxt = 7'd0;
                    w_ffv_nxt       = 3'd0;
                    w_ffvalid_nxt   = 1'b0;
                    w_pass_nxt      = 1'b0;
`ifdef GATES_SWEEP_LOG_EN
                    w_log_nxt       = 56'd0;
`endif
                end
            end
            StRun: begin
                if (r_wcnt != SettleW) begin
                    w_wcnt_nxt = r_wcnt + 4'd1;
                end else begin
                    w_wcnt_nxt      = 4'd0;
                    w_fail_mask_nxt = r_fail_mask | w_diff;
                    if ((w_diff != 7'd0) && !r_ffvalid) begin
                        w_ffv_nxt     = r_vec;
                        w_ffvalid_nxt = 1'b1;
                    end
`ifdef GATES_SWEEP_LOG_EN
                    w_log_nxt[7*r_vec +: 7] = io_bank.gate_out;
`endif
                    // Pass is resolved on entry to DONE so it is valid alongside the done pulse.
                    if (r_vec == 3'd7) begin
                        w_state_nxt = StDone;
                        w_pass_nxt  = (w_fail_mask_nxt == 7'd0);
                    end else begin
                        w_vec_nxt = r_vec + 3'd1;
                    end
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
        w_drive_nxt = (w_state_nxt == StRun) ? w_vec_nxt : 3'd0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_vec       <= 3'd0;
            r_wcnt      <= 4'd0;
            r_drive     <= 3'd0;
            r_fail_mask <= 7'd0;
            r_ffv       <= 3'd0;
            r_ffvalid   <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_vec       <= w_vec_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_drive     <= w_drive_nxt;
            r_fail_mask <= w_fail_mask_nxt;
            r_ffv       <= w_ffv_nxt;
            r_ffvalid   <= w_ffvalid_nxt;
            r_pass      <= w_pass_nxt;
        end
    end

`ifdef GATES_SWEEP_LOG_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_log <= 56'd0;
        end else begin
            r_log <= w_log_nxt;
        end
    end

    assign o_result_log = r_log;
`endif

    assign io_bank.in0        = r_drive[0];
    assign io_bank.in1        = r_drive[1];
    assign io_bank.sel        = r_drive[2];
    assign o_busy             = (r_state == StRun);
    assign o_done             = (r_state == StDone);
    assign o_pass             = r_pass;
    assign o_fail_mask        = r_fail_mask;
    assign o_first_fail_vec   = r_ffv;
    assign o_first_fail_valid = r_ffvalid;

endmodule

// File: tb/tb_gates_sweep_ctrl.sv
// Bench for gates_sweep_ctrl: two instances (SETTLE=2 and SETTLE=0) driving modelled gate banks
// with injectable faults; expected sweep results are queued at acceptance and checked at done.
`timescale 1ns/1ps
module tb_gates_sweep_ctrl;

    localparam int unsigned S0 = 2;
    localparam int unsigned S1 = 0;

    typedef struct {
        logic        pass;
        logic [6:0]  mask;
        logic [2:0]  ffv;
        logic        ffvalid;
        logic [55:0] log;
    } exp_t;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [1:0] start;
    logic [1:0] busy;
    logic [1:0] done;
    logic [1:0] pass;
    logic [1:0] ffvalid;
    logic [6:0] mask [2];
    logic [2:0] ffv [2];
    logic [2:0] drv [2];
    int unsigned mode [2];
`ifdef GATES_SWEEP_LOG_EN
    logic [55:0] rlog [2];
`endif

    int   n_checks = 0;
    int   n_pass = 0;
    int   m_cnt [2];
    bit   [1:0] m_rst_q = 2'b00;
    exp_t sb_q0 [$];
    exp_t sb_q1 [$];
    exp_t h_exp [2];
    bit   [1:0] h_valid = 2'b00;

    always #5 clk = ~clk;

    gates_sweep_ctrl_if bus0 ();
    gates_sweep_ctrl_if bus1 ();

    gates_sweep_ctrl #(.SETTLE(S0)) u_dut0 (
        .i_clk              (clk),
        .i_reset            (rst[0]),
        .i_start            (start[0]),
        .io_bank            (bus0),
        .o_busy             (busy[0]),
        .o_done             (done[0]),
        .o_pass             (pass[0]),
        .o_fail_mask        (mask[0]),
        .o_first_fail_vec   (ffv[0]),
        .o_first_fail_valid (ffvalid[0])
`ifdef GATES_SWEEP_LOG_EN
        ,
        .o_result_log       (rlog[0])
`endif
    );

    gates_sweep_ctrl #(.SETTLE(S1)) u_dut1 (
        .i_clk              (clk),
        .i_reset            (rst[1]),
        .i_start            (start[1]),
        .io_bank            (bus1),
        .o_busy             (busy[1]),
        .o_done             (done[1]),
        .o_pass             (pass[1]),
        .o_fail_mask        (mask[1]),
        .o_first_fail_vec   (ffv[1]),
        .o_first_fail_valid (ffvalid[1])
`ifdef GATES_SWEEP_LOG_EN
        ,
        .o_result_log       (rlog[1])
`endif
    );

    function automatic logic [6:0] golden(input logic [2:0] v);
        logic in0, in1, sel;
        in0 = v[0];
        in1 = v[1];
        sel = v[2];
        return {in0 & sel, in0 & ~sel, sel ? in1 : in0, in0 ^ in1, in0 | in1, in0 & in1, ~in0};
    endfunction

    // Mode 0: ideal bank, 1: and stuck at 0, 2: mux with inverted select.
    function automatic logic [6:0] bank(input logic [2:0] v, input int unsigned m);
        logic [6:0] g;
        g = golden(v);
        if (m == 1) g[1] = 1'b0;
        if (m == 2) g[4] = v[2] ? v[0] : v[1];
        return g;
    endfunction

    function automatic exp_t exp_for(input int unsigned m);
        exp_t       e;
        logic [2:0] v;
        logic [6:0] x;
        e.pass = 1'b0;
        e.mask = 7'd0;
        e.ffv = 3'd0;
        e.ffvalid = 1'b0;
        e.log = 56'd0;
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            x = golden(v) ^ bank(v, m);
            e.mask = e.mask | x;
            if ((x != 7'd0) && !e.ffvalid) begin
                e.ffv = v;
                e.ffvalid = 1'b1;
            end
            e.log[7*k +: 7] = bank(v, m);
        end
        e.pass = (e.mask == 7'd0);
        return e;
    endfunction

    function automatic int settle_of(input int i);
        return (i == 0) ? int'(S0) : int'(S1);
    endfunction

    function automatic int sweep_len(input int i);
        return 8 * (settle_of(i) + 1);
    endfunction

    always_comb bus0.gate_out = bank({bus0.sel, bus0.in1, bus0.in0}, mode[0]);
    always_comb bus1.gate_out = bank({bus1.sel, bus1.in1, bus1.in0}, mode[1]);
    assign drv[0] = {bus0.sel, bus0.in1, bus0.in0};
    assign drv[1] = {bus1.sel, bus1.in1, bus1.in0};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Timing model: m_cnt is 0 in IDLE, 1..L during RUN, L+1 in the DONE cycle.
    initial begin
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                m_rst_q[i] = rst[i];
                if (rst[i]) begin
                    if (m_cnt[i] >= 1 && m_cnt[i] <= sweep_len(i)) begin
                        if (i == 0 && sb_q0.size() > 0) void'(sb_q0.pop_back());
                        if (i == 1 && sb_q1.size() > 0) void'(sb_q1.pop_back());
                    end
                    m_cnt[i] = 0;
                end else if (m_cnt[i] == 0) begin
                    if (start[i]) begin
                        m_cnt[i] = 1;
                        if (i == 0) sb_q0.push_back(exp_for(mode[0]));
                        else sb_q1.push_back(exp_for(mode[1]));
                    end
                end else if (m_cnt[i] == sweep_len(i) + 1) begin
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
    end

    initial begin
        exp_t e;
        logic exp_busy;
        logic got_one;
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                exp_busy = (m_cnt[i] >= 1) && (m_cnt[i] <= sweep_len(i));
                chk($sformatf("busy[%0d]", i), 64'(busy[i]), 64'(exp_busy));
                chk($sformatf("done[%0d]", i), 64'(done[i]), 64'(m_cnt[i] == sweep_len(i) + 1));
                if (exp_busy) begin
                    chk($sformatf("drive[%0d]", i), 64'(drv[i]),
                        64'((m_cnt[i] - 1) / (settle_of(i) + 1)));
                end else if (m_cnt[i] == 0) begin
                    chk($sformatf("idle_drive[%0d]", i), 64'(drv[i]), 64'd0);
                end
                if (m_rst_q[i] || exp_busy) h_valid[i] = 1'b0;
                if (m_cnt[i] == 1) begin
                    chk($sformatf("clr_pass[%0d]", i), 64'(pass[i]), 64'd0);
                    chk($sformatf("clr_mask[%0d]", i), 64'(mask[i]), 64'd0);
                    chk($sformatf("clr_ffvalid[%0d]", i), 64'(ffvalid[i]), 64'd0);
                end
                if (done[i]) begin
                    got_one = (i == 0) ? (sb_q0.size() > 0) : (sb_q1.size() > 0);
                    chk($sformatf("sb_nonempty[%0d]", i), 64'(got_one), 64'd1);
                    if (got_one) begin
                        e = (i == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
                        chk($sformatf("pass[%0d]", i), 64'(pass[i]), 64'(e.pass));
                        chk($sformatf("fail_mask[%0d]", i), 64'(mask[i]), 64'(e.mask));
                        chk($sformatf("ffvalid[%0d]", i), 64'(ffvalid[i]), 64'(e.ffvalid));
                        chk($sformatf("ffv[%0d]", i), 64'(ffv[i]), 64'(e.ffv));
`ifdef GATES_SWEEP_LOG_EN
                        chk($sformatf("log[%0d]", i), 64'(rlog[i]), 64'(e.log));
`endif
                        h_exp[i] = e;
                        h_valid[i] = 1'b1;
                    end
                end else if (m_cnt[i] == 0) begin
                    chk($sformatf("hold_pass[%0d]", i), 64'(pass[i]),
                        h_valid[i] ? 64'(h_exp[i].pass) : 64'd0);
                    chk($sformatf("hold_mask[%0d]", i), 64'(mask[i]),
                        h_valid[i] ? 64'(h_exp[i].mask) : 64'd0);
                    chk($sformatf("hold_ffvalid[%0d]", i), 64'(ffvalid[i]),
                        h_valid[i] ? 64'(h_exp[i].ffvalid) : 64'd0);
                    chk($sformatf("hold_ffv[%0d]", i), 64'(ffv[i]),
                        h_valid[i] ? 64'(h_exp[i].ffv) : 64'd0);
                end
            end
        end
    end

    task automatic pulse(input int i);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk($sformatf("done_timeout[%0d]", i), 64'd0, 64'd1);
    endtask

    initial begin
        logic hit;
        rst = 2'b11;
        start = 2'b00;
        mode[0] = 0;
        mode[1] = 0;
        repeat (3) @(negedge clk);
        rst = 2'b00;
        repeat (2) @(negedge clk);

        pulse(0);
        wait_done(0, 60);
        repeat (3) @(negedge clk);

        mode[0] = 1;
        pulse(0);
        wait_done(0, 60);
        repeat (3) @(negedge clk);

        mode[1] = 2;
        pulse(1);
        wait_done(1, 30);
        repeat (3) @(negedge clk);

        mode[0] = 0;
        start[0] = 1'b1;
        repeat (3) wait_done(0, 60);
        start[0] = 1'b0;
        repeat (4) @(negedge clk);

        // Partial results exist by RUN cycle 10 (mismatch sampled at vec 1).
        mode[0] = 2;
        pulse(0);
        hit = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (m_cnt[0] == 10) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_run10", 64'(hit), 64'd1);
        chk("partial_ffvalid", 64'(ffvalid[0]), 64'd1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        repeat (3) @(negedge clk);

        mode[0] = 0;
        pulse(0);
        wait_done(0, 60);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
